// File: rtl/ddr_cmd_exec_if.sv
// Bundle of the cmd_fifo pop port, DDR controller channels and user read return.
// master = executor side, slave = FIFO/controller/user side.
interface ddr_cmd_exec_if #(
    parameter int unsigned TYPE_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned BRST_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MASK_WIDTH = 16
);
    logic                  fifo_pop_valid;
    logic                  fifo_pop_ready;
    logic [TYPE_WIDTH-1:0] fifo_type;
    logic [ADDR_WIDTH-1:0] fifo_addr;
    logic [BRST_WIDTH-1:0] fifo_burst_cnt;
    logic [DATA_WIDTH-1:0] fifo_wt_data;
    logic [MASK_WIDTH-1:0] fifo_wt_mask;

    logic                  ddr_cmd_valid;
    logic                  ddr_cmd_ready;
    logic                  ddr_cmd_wr;
    logic [ADDR_WIDTH-1:0] ddr_cmd_addr;
    logic [BRST_WIDTH-1:0] ddr_cmd_len;

    logic                  ddr_wdata_valid;
    logic                  ddr_wdata_ready;
    logic [DATA_WIDTH-1:0] ddr_wdata;
    logic [MASK_WIDTH-1:0] ddr_wmask;
    logic                  ddr_wlast;

    logic                  ddr_rdata_valid;
    logic [DATA_WIDTH-1:0] ddr_rdata;

    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;

    logic                  busy;
    logic [1:0]            err;

    modport master (
        output fifo_pop_valid,
        input  fifo_pop_ready, fifo_type, fifo_addr, fifo_burst_cnt, fifo_wt_data, fifo_wt_mask,
        output ddr_cmd_valid, ddr_cmd_wr, ddr_cmd_addr, ddr_cmd_len,
        input  ddr_cmd_ready,
        output ddr_wdata_valid, ddr_wdata, ddr_wmask, ddr_wlast,
        input  ddr_wdata_ready,
        input  ddr_rdata_valid, ddr_rdata,
        output rd_valid, rd_data, rd_last,
        output busy, err
    );

    modport slave (
        input  fifo_pop_valid,
        output fifo_pop_ready, fifo_type, fifo_addr, fifo_burst_cnt, fifo_wt_data, fifo_wt_mask,
        input  ddr_cmd_valid, ddr_cmd_wr, ddr_cmd_addr, ddr_cmd_len,
        output ddr_cmd_ready,
        input  ddr_wdata_valid, ddr_wdata, ddr_wmask, ddr_wlast,
        output ddr_wdata_ready,
        output ddr_rdata_valid, ddr_rdata,
        input  rd_valid, rd_data, rd_last,
        input  busy, err
    );
endinterface

// File: rtl/ddr_cmd_exec.sv
// Pop-side executor: drains cmd_fifo entries into DDR command / write-data
// transactions and returns read bursts to the user side.
module ddr_cmd_exec #(
    parameter int unsigned TYPE_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned BRST_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MASK_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    ddr_cmd_exec_if.master   bus
);
    localparam int unsigned BEAT_WIDTH = BRST_WIDTH + 1;
    localparam logic [TYPE_WIDTH-1:0] FIFO_IDE_TYPE = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] FIFO_WT_TYPE  = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] FIFO_RD_TYPE  = TYPE_WIDTH'(2);

    typedef enum logic [1:0] {ST_IDLE, ST_WT, ST_RD_CMD, ST_RD_DATA} state_t;

    state_t                r_state,     w_state;
    logic                  r_cmd_valid, w_cmd_valid;
    logic                  r_cmd_wr,    w_cmd_wr;
    logic [ADDR_WIDTH-1:0] r_cmd_addr,  w_cmd_addr;
    logic [BRST_WIDTH-1:0] r_cmd_len,   w_cmd_len;
    logic                  r_wd_valid,  w_wd_valid;
    logic [DATA_WIDTH-1:0] r_wd_data,   w_wd_data;
    logic [MASK_WIDTH-1:0] r_wd_mask,   w_wd_mask;
    logic                  r_wd_last,   w_wd_last;
    logic [BEAT_WIDTH-1:0] r_beat,      w_beat;
    logic                  r_rd_valid,  w_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data,   w_rd_data;
    logic                  r_rd_last,   w_rd_last;
    logic [1:0]            r_err,       w_err;
    logic                  w_pop_valid;
    logic                  w_cmd_hs;
    logic                  w_wd_hs;
    logic [BEAT_WIDTH-1:0] w_len_ext;

    assign w_cmd_hs  = r_cmd_valid && bus.ddr_cmd_ready;
    assign w_wd_hs   = r_wd_valid && bus.ddr_wdata_ready;
    assign w_len_ext = BEAT_WIDTH'(r_cmd_len);

    // Next-state and next-register logic
    always_comb begin
        w_state     = r_state;
        w_cmd_valid = r_cmd_valid;
        w_cmd_wr    = r_cmd_wr;
        w_cmd_addr  = r_cmd_addr;
        w_cmd_len   = r_cmd_len;
        w_wd_valid  = r_wd_valid;
        w_wd_data   = r_wd_data;
        w_wd_mask   = r_wd_mask;
        w_wd_last   = r_wd_last;
        w_beat      = r_beat;
        w_rd_valid  = 1'b0;
        w_rd_data   = r_rd_data;
        w_rd_last   = 1'b0;
        w_err       = r_err;
        w_pop_valid = 1'b0;

        if (w_cmd_hs) w_cmd_valid = 1'b0;
        if (w_wd_hs)  w_wd_valid  = 1'b0;
        if (bus.ddr_rdata_valid && (r_state != ST_RD_DATA)) w_err[1] = 1'b1;

        case (r_state)
            ST_IDLE: begin
                w_pop_valid = 1'b1;
                if (bus.fifo_pop_ready) begin
                    if (bus.fifo_type == FIFO_WT_TYPE) begin
                        w_cmd_valid = 1'b1;
                        w_cmd_wr    = 1'b1;
                        w_cmd_addr  = bus.fifo_addr;
                        w_cmd_len   = bus.fifo_burst_cnt;
                        w_wd_valid  = 1'b1;
                        w_wd_data   = bus.fifo_wt_data;
                        w_wd_mask   = bus.fifo_wt_mask;
                        w_wd_last   = (bus.fifo_burst_cnt == '0);
                        w_beat      = BEAT_WIDTH'(1);
                        w_state     = ST_WT;
                    end else if (bus.fifo_type == FIFO_RD_TYPE) begin
                        w_cmd_valid = 1'b1;
                        w_cmd_wr    = 1'b0;
                        w_cmd_addr  = bus.fifo_addr;
                        w_cmd_len   = bus.fifo_burst_cnt;
                        w_state     = ST_RD_CMD;
                    end
                    // FIFO_IDE_TYPE and unknown types are discarded
                end
            end
            ST_WT: begin
                // Refill the single wdata slot only when it is empty or draining now
                w_pop_valid = (r_beat <= w_len_ext) && (!r_wd_valid || bus.ddr_wdata_ready);
                if (w_pop_valid && bus.fifo_pop_ready) begin
                    w_wd_valid = 1'b1;
                    w_wd_data  = bus.fifo_wt_data;
                    w_wd_mask  = bus.fifo_wt_mask;
                    w_wd_last  = (r_beat == w_len_ext);
                    w_beat     = r_beat + BEAT_WIDTH'(1);
                    if (bus.fifo_type != FIFO_WT_TYPE) w_err[0] = 1'b1;
                end
                if ((r_beat > w_len_ext) && (!r_wd_valid || bus.ddr_wdata_ready) &&
                    (!r_cmd_valid || bus.ddr_cmd_ready)) begin
                    w_state = ST_IDLE;
                end
            end
            ST_RD_CMD: begin
                if (w_cmd_hs) begin
                    w_beat  = '0;
                    w_state = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (bus.ddr_rdata_valid) begin
                    w_rd_valid = 1'b1;
                    w_rd_data  = bus.ddr_rdata;
                    w_rd_last  = (r_beat == w_len_ext);
                    w_beat     = r_beat + BEAT_WIDTH'(1);
                    if (r_beat == w_len_ext) w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_wr    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_len   <= '0;
            r_wd_valid  <= 1'b0;
            r_wd_data   <= '0;
            r_wd_mask   <= '0;
            r_wd_last   <= 1'b0;
            r_beat      <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_last   <= 1'b0;
            r_err       <= '0;
        end else begin
            r_state     <= w_state;
            r_cmd_valid <= w_cmd_valid;
            r_cmd_wr    <= w_cmd_wr;
            r_cmd_addr  <= w_cmd_addr;
            r_cmd_len   <= w_cmd_len;
            r_wd_valid  <= w_wd_valid;
            r_wd_data   <= w_wd_data;
            r_wd_mask   <= w_wd_mask;
            r_wd_last   <= w_wd_last;
            r_beat      <= w_beat;
            r_rd_valid  <= w_rd_valid;
            r_rd_data   <= w_rd_data;
            r_rd_last   <= w_rd_last;
            r_err       <= w_err;
        end
    end

    // Pop request is combinational on the handshake inputs; held low in reset
    assign bus.fifo_pop_valid  = w_pop_valid && !rst;
    assign bus.ddr_cmd_valid   = r_cmd_valid;
    assign bus.ddr_cmd_wr      = r_cmd_wr;
    assign bus.ddr_cmd_addr    = r_cmd_addr;
    assign bus.ddr_cmd_len     = r_cmd_len;
    assign bus.ddr_wdata_valid = r_wd_valid;
    assign bus.ddr_wdata       = r_wd_data;
    assign bus.ddr_wmask       = r_wd_mask;
    assign bus.ddr_wlast       = r_wd_last;
    assign bus.rd_valid        = r_rd_valid;
    assign bus.rd_data         = r_rd_data;
    assign bus.rd_last         = r_rd_last;
    assign bus.busy            = (r_state != ST_IDLE);
    assign bus.err             = r_err;
endmodule

// File: tb/tb_ddr_cmd_exec.sv
// Directed self-checking bench for ddr_cmd_exec: models cmd_fifo, the DDR
// controller channels and logs every handshake for comparison.
module tb_ddr_cmd_exec;
    localparam int unsigned AW = 27;
    localparam int unsigned BW = 6;
    localparam int unsigned DW = 128;
    localparam int unsigned MW = 16;
    localparam logic [1:0] T_IDE = 2'd0;
    localparam logic [1:0] T_WT  = 2'd1;
    localparam logic [1:0] T_RD  = 2'd2;

    typedef struct packed {
        logic [1:0]    typ;
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } ent_t;
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] len;
    } cmd_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        logic          last;
    } wd_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddr_cmd_exec_if bus ();
    ddr_cmd_exec dut (.clk(clk), .rst(rst), .bus(bus));

    ent_t       fq[$];
    cmd_t       cmd_log[$];
    wd_t        wd_log[$];
    rd_t        rd_log[$];
    logic [1:0] pop_typ[$];
    int         pop_cyc[$], cmd_cyc[$], wd_cyc[$], rd_cyc[$], rdv_cyc[$];
    int         cyc, n_chk, n_pass, stab_err, bad_pop;
    logic          cmd_rdy, wd_rdy, rdv;
    logic [DW-1:0] rdd;
    logic          p_cstall, p_wstall;
    cmd_t          p_cmd, cur_cmd;
    wd_t           p_wd, cur_wd;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic ent_t mk(input logic [1:0] t, input logic [AW-1:0] a,
                                input logic [BW-1:0] b, input logic [DW-1:0] d,
                                input logic [MW-1:0] m);
        ent_t e;
        e.typ = t; e.addr = a; e.bc = b; e.data = d; e.mask = m;
        return e;
    endfunction

    task automatic clr_logs();
        cmd_log.delete(); wd_log.delete(); rd_log.delete(); pop_typ.delete();
        pop_cyc.delete(); cmd_cyc.delete(); wd_cyc.delete(); rd_cyc.delete(); rdv_cyc.delete();
    endtask

    // One clock: drive inputs at negedge, then record what the next posedge will see
    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.fifo_pop_ready = (fq.size() != 0);
        if (fq.size() != 0) begin
            bus.fifo_type = fq[0].typ; bus.fifo_addr = fq[0].addr;
            bus.fifo_burst_cnt = fq[0].bc; bus.fifo_wt_data = fq[0].data;
            bus.fifo_wt_mask = fq[0].mask;
        end else begin
            bus.fifo_type = '0; bus.fifo_addr = '0; bus.fifo_burst_cnt = '0;
            bus.fifo_wt_data = '0; bus.fifo_wt_mask = '0;
        end
        bus.ddr_cmd_ready   = cmd_rdy;
        bus.ddr_wdata_ready = wd_rdy;
        bus.ddr_rdata_valid = rdv;
        bus.ddr_rdata       = rdd;
        if (rdv) rdv_cyc.push_back(cyc);
        #1;
        cur_cmd = {bus.ddr_cmd_wr, bus.ddr_cmd_addr, bus.ddr_cmd_len};
        cur_wd  = {bus.ddr_wdata, bus.ddr_wmask, bus.ddr_wlast};
        if (p_cstall && (!bus.ddr_cmd_valid || cur_cmd != p_cmd)) stab_err++;
        if (p_wstall && (!bus.ddr_wdata_valid || cur_wd != p_wd)) stab_err++;
        p_cstall = bus.ddr_cmd_valid && !bus.ddr_cmd_ready;
        p_wstall = bus.ddr_wdata_valid && !bus.ddr_wdata_ready;
        p_cmd = cur_cmd;
        p_wd  = cur_wd;
        if (bus.fifo_pop_valid && bus.fifo_pop_ready) begin
            if (bus.busy && !bus.ddr_cmd_wr) bad_pop++;
            pop_cyc.push_back(cyc);
            pop_typ.push_back(fq[0].typ);
            fq.delete(0);
        end
        if (bus.ddr_cmd_valid && bus.ddr_cmd_ready) begin
            cmd_log.push_back(cur_cmd); cmd_cyc.push_back(cyc);
        end
        if (bus.ddr_wdata_valid && bus.ddr_wdata_ready) begin
            wd_log.push_back(cur_wd); wd_cyc.push_back(cyc);
        end
        if (bus.rd_valid) begin
            rd_log.push_back({bus.rd_data, bus.rd_last}); rd_cyc.push_back(cyc);
        end
    endtask

    task automatic run_idle(input string tag, input int max);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((fq.size() != 0 || bus.busy) && n < max);
        chk({tag, "_done"}, 160'((fq.size() == 0) && !bus.busy), 160'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] base;
        int n, dcyc;
        n_chk = 0; n_pass = 0; stab_err = 0; bad_pop = 0; cyc = 0;
        cmd_rdy = 1'b1; wd_rdy = 1'b1; rdv = 1'b0; rdd = '0;
        p_cstall = 1'b0; p_wstall = 1'b0; p_cmd = '0; p_wd = '0;
        bus.fifo_pop_ready = 1'b0; bus.fifo_type = '0; bus.fifo_addr = '0;
        bus.fifo_burst_cnt = '0; bus.fifo_wt_data = '0; bus.fifo_wt_mask = '0;
        bus.ddr_cmd_ready = 1'b0; bus.ddr_wdata_ready = 1'b0;
        bus.ddr_rdata_valid = 1'b0; bus.ddr_rdata = '0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_pop_valid", 160'(bus.fifo_pop_valid), 160'(0));
        chk("rst_busy", 160'(bus.busy), 160'(0));
        chk("rst_err", 160'(bus.err), 160'(0));
        chk("rst_cmd_valid", 160'(bus.ddr_cmd_valid), 160'(0));
        chk("rst_wd_valid", 160'(bus.ddr_wdata_valid), 160'(0));
        chk("rst_rd_valid", 160'(bus.rd_valid), 160'(0));
        rst = 1'b0;
        tick();

        // 8-beat write, all ready
        clr_logs();
        base = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        for (int i = 0; i < 8; i++)
            fq.push_back(mk(T_WT, (i == 0) ? 27'h5 : 27'(27'h100 + i), (i == 0) ? 6'd7 : 6'd0,
                            base + 128'(i), 16'(16'hFFFF >> i)));
        run_idle("wt8", 40);
        chk("wt8_ncmd", 160'(cmd_log.size()), 160'(1));
        chk("wt8_cmd", 160'(cmd_log[0]), 160'({1'b1, 27'h5, 6'd7}));
        chk("wt8_nbeats", 160'(wd_log.size()), 160'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wt8_data%0d", i), 160'(wd_log[i].data), 160'(base + 128'(i)));
            chk($sformatf("wt8_mask%0d", i), 160'(wd_log[i].mask), 160'(16'hFFFF >> i));
            chk($sformatf("wt8_last%0d", i), 160'(wd_log[i].last), 160'(i == 7));
        end
        chk("wt8_cmd_lat", 160'(cmd_cyc[0] - pop_cyc[0]), 160'(1));
        chk("wt8_wd_lat", 160'(wd_cyc[0] - pop_cyc[0]), 160'(1));
        chk("wt8_b2b", 160'(wd_cyc[7] - wd_cyc[0]), 160'(7));
        chk("wt8_err", 160'(bus.err), 160'(0));

        // 8-beat read with gaps; an IDE behind must wait for the burst
        clr_logs();
        fq.push_back(mk(T_RD, 27'h2, 6'd7, '0, '0));
        fq.push_back(mk(T_IDE, 27'h0, 6'd0, '0, '0));
        n = 0;
        while (cmd_log.size() == 0 && n < 20) begin tick(); n++; end
        chk("rd_cmd_seen", 160'(cmd_log.size()), 160'(1));
        chk("rd_cmd", 160'(cmd_log[0]), 160'({1'b0, 27'h2, 6'd7}));
        for (int i = 0; i < 8; i++) begin
            repeat (i % 3) tick();
            rdv = 1'b1; rdd = 128'(32'hBEEF_0000 + i);
            tick();
            rdv = 1'b0; rdd = '0;
        end
        tick();
        run_idle("rd8", 20);
        chk("rd_nbeats", 160'(rd_log.size()), 160'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rd_data%0d", i), 160'(rd_log[i].data), 160'(32'hBEEF_0000 + i));
            chk($sformatf("rd_last%0d", i), 160'(rd_log[i].last), 160'(i == 7));
            chk($sformatf("rd_lat%0d", i), 160'(rd_cyc[i] - rdv_cyc[i]), 160'(1));
        end
        chk("rd_no_pop", 160'(bad_pop), 160'(0));
        chk("rd_npops", 160'(pop_typ.size()), 160'(2));
        chk("rd_ide_after", 160'(pop_cyc[1] > rd_cyc[7] - 1), 160'(1));
        chk("rd_err", 160'(bus.err), 160'(0));

        // Backpressure: command held off 12 cycles, wdata ready toggling
        clr_logs();
        for (int i = 0; i < 4; i++)
            fq.push_back(mk(T_WT, 27'h40, 6'd3, 128'(32'hC0DE_0000 + i), 16'(16'h00FF << i)));
        dcyc = 0;
        for (int k = 0; k < 60; k++) begin
            cmd_rdy = (k >= 12);
            wd_rdy  = (k % 2 == 1);
            tick();
            if (!bus.busy && fq.size() == 0 && wd_log.size() != 0) begin dcyc = cyc; break; end
        end
        cmd_rdy = 1'b1; wd_rdy = 1'b1;
        chk("bp_done", 160'(dcyc != 0), 160'(1));
        chk("bp_ncmd", 160'(cmd_log.size()), 160'(1));
        chk("bp_cmd", 160'(cmd_log[0]), 160'({1'b1, 27'h40, 6'd3}));
        chk("bp_nbeats", 160'(wd_log.size()), 160'(4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_data%0d", i), 160'(wd_log[i].data), 160'(32'hC0DE_0000 + i));
            chk($sformatf("bp_last%0d", i), 160'(wd_log[i].last), 160'(i == 3));
        end
        chk("bp_beats_first", 160'(wd_cyc[3] < cmd_cyc[0]), 160'(1));
        chk("bp_exit", 160'(dcyc - cmd_cyc[0]), 160'(1));
        chk("bp_stable", 160'(stab_err), 160'(0));

        // Single-beat write followed by an IDE entry
        clr_logs();
        fq.push_back(mk(T_WT, 27'h10, 6'd0, 128'h77, 16'h0001));
        fq.push_back(mk(T_IDE, 27'h3, 6'd5, 128'h99, 16'h0002));
        run_idle("wt1", 20);
        chk("wt1_cmd", 160'(cmd_log[0]), 160'({1'b1, 27'h10, 6'd0}));
        chk("wt1_ncmd", 160'(cmd_log.size()), 160'(1));
        chk("wt1_nbeats", 160'(wd_log.size()), 160'(1));
        chk("wt1_beat", 160'(wd_log[0]), 160'({128'h77, 16'h0001, 1'b1}));
        chk("wt1_ide_pop", 160'(pop_typ[1]), 160'(T_IDE));
        chk("wt1_turnaround", 160'(pop_cyc[1] - pop_cyc[0]), 160'(2));

        // Protocol errors: RD inside a write burst, stray read beat in IDLE
        clr_logs();
        fq.push_back(mk(T_WT, 27'h20, 6'd3, 128'hE0, 16'h000F));
        fq.push_back(mk(T_WT, 27'h0, 6'd0, 128'hE1, 16'h00F0));
        fq.push_back(mk(T_RD, 27'h7, 6'd9, 128'hE2, 16'h0F00));
        fq.push_back(mk(T_WT, 27'h0, 6'd0, 128'hE3, 16'hF000));
        run_idle("err", 20);
        chk("err_bit0", 160'(bus.err), 160'(2'b01));
        chk("err_nbeats", 160'(wd_log.size()), 160'(4));
        chk("err_fwd_beat", 160'(wd_log[2]), 160'({128'hE2, 16'h0F00, 1'b0}));
        chk("err_ncmd", 160'(cmd_log.size()), 160'(1));
        rdv = 1'b1; rdd = 128'hDEAD;
        tick();
        rdv = 1'b0; rdd = '0;
        tick(); tick();
        chk("err_bit1", 160'(bus.err), 160'(2'b11));
        chk("err_no_rd", 160'(rd_log.size()), 160'(0));

        // Reset in the middle of a write burst
        clr_logs();
        for (int i = 0; i < 8; i++)
            fq.push_back(mk(T_WT, 27'h30, 6'd7, 128'(i), 16'hFFFF));
        n = 0;
        while (wd_log.size() < 3 && n < 20) begin tick(); n++; end
        chk("rstm_progress", 160'(wd_log.size()), 160'(3));
        rst = 1'b1;
        #1;
        chk("rstm_pop_valid", 160'(bus.fifo_pop_valid), 160'(0));
        chk("rstm_cmd_valid", 160'(bus.ddr_cmd_valid), 160'(0));
        chk("rstm_cmd_fields", 160'({bus.ddr_cmd_wr, bus.ddr_cmd_addr, bus.ddr_cmd_len}), 160'(0));
        chk("rstm_wd", 160'({bus.ddr_wdata_valid, bus.ddr_wlast, bus.ddr_wmask}), 160'(0));
        chk("rstm_wdata", 160'(bus.ddr_wdata), 160'(0));
        chk("rstm_busy", 160'(bus.busy), 160'(0));
        chk("rstm_err", 160'(bus.err), 160'(0));
        fq.delete();
        p_cstall = 1'b0; p_wstall = 1'b0;
        clr_logs();
        fq.push_back(mk(T_IDE, 27'h0, 6'd0, '0, '0));
        tick(); tick();
        chk("rstm_no_pop", 160'(pop_typ.size()), 160'(0));
        rst = 1'b0;
        fq.push_back(mk(T_WT, 27'h50, 6'd1, 128'hA0, 16'h1234));
        fq.push_back(mk(T_WT, 27'h0, 6'd0, 128'hA1, 16'h5678));
        run_idle("rstm_after", 20);
        chk("rstm_ncmd", 160'(cmd_log.size()), 160'(1));
        chk("rstm_cmd", 160'(cmd_log[0]), 160'({1'b1, 27'h50, 6'd1}));
        chk("rstm_nbeats", 160'(wd_log.size()), 160'(2));
        chk("rstm_beat0", 160'(wd_log[0]), 160'({128'hA0, 16'h1234, 1'b0}));
        chk("rstm_beat1", 160'(wd_log[1]), 160'({128'hA1, 16'h5678, 1'b1}));
        chk("final_stable", 160'(stab_err), 160'(0));
        chk("final_no_rd_pop", 160'(bad_pop), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
